// File: rtl/dsd7_pit_pkg.sv
// Shared register map, CTRL bit positions and control struct for the DSD7 interval timer.
// Latency/backpressure: n/a (definitions only).
package dsd7_pit_pkg;

    localparam logic [1:0] REG_COUNT = 2'd0;
    localparam logic [1:0] REG_MAX   = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_STAT  = 2'd3;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_GE = 2;
    localparam int CTRL_LD = 3;
    localparam int CTRL_IE = 4;

    // Field order mirrors CTRL[4:0]; ld is never stored so it always reads back 0.
    typedef struct packed {
        logic ie;
        logic ld;
        logic ge;
        logic ar;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] merge_halves(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [1:0]  sel);
        logic [31:0] res;
        res = old_val;
        if (sel[0]) res[15:0]  = new_val[15:0];
        if (sel[1]) res[31:16] = new_val[31:16];
        return res;
    endfunction

endpackage

// File: rtl/dsd7_pit_chan.sv
// One timer channel: COUNT/MAX/CTRL/FLAG state, 2-flop gate synchronizer, registered irq.
// Latency: register writes take effect next clock, irq one clock after FLAG; no backpressure.
module dsd7_pit_chan
    import dsd7_pit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tick,
    input  logic        i_gate,
    input  logic        i_we_count,
    input  logic        i_we_max,
    input  logic        i_we_ctrl,
    input  logic        i_we_stat,
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_dat,
    output logic [31:0] o_count,
    output logic [31:0] o_max,
    output ctrl_t       o_ctrl,
    output logic        o_flag,
    output logic        o_irq
);

    logic [31:0] r_count, r_max;
    ctrl_t       r_ctrl;
    logic        r_flag, r_irq, r_gate_s1, r_gate_s2;

    logic [31:0] w_count_nxt, w_max_nxt;
    ctrl_t       w_ctrl_nxt;
    logic        w_flag_nxt, w_run, w_unf;

    // Later assignments win: tick < LD < COUNT write; STAT clear < underflow set.
    always_comb begin
        w_run       = i_tick & r_ctrl.en & (~r_ctrl.ge | r_gate_s2);
        w_unf       = w_run & (r_count == 32'd0);
        w_count_nxt = r_count;
        w_max_nxt   = r_max;
        w_ctrl_nxt  = r_ctrl;
        w_flag_nxt  = r_flag;

        if (w_run) begin
            if (r_count != 32'd0)  w_count_nxt    = r_count - 32'd1;
            else if (r_ctrl.ar)    w_count_nxt    = r_max;
            else                   w_ctrl_nxt.en  = 1'b0;
        end

        if (i_we_max) w_max_nxt = merge_halves(r_max, i_dat, i_sel);

        if (i_we_ctrl && i_sel[0]) begin
            w_ctrl_nxt.en = i_dat[CTRL_EN];
            w_ctrl_nxt.ar = i_dat[CTRL_AR];
            w_ctrl_nxt.ge = i_dat[CTRL_GE];
            w_ctrl_nxt.ie = i_dat[CTRL_IE];
            w_ctrl_nxt.ld = 1'b0;
            if (i_dat[CTRL_LD]) w_count_nxt = r_max;
        end

        if (i_we_count) w_count_nxt = merge_halves(r_count, i_dat, i_sel);

        if (i_we_stat && i_sel[0] && i_dat[0]) w_flag_nxt = 1'b0;
        if (w_unf) w_flag_nxt = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count   <= '0;
            r_max     <= '0;
            r_ctrl    <= '0;
            r_flag    <= 1'b0;
            r_irq     <= 1'b0;
            r_gate_s1 <= 1'b0;
            r_gate_s2 <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_max     <= w_max_nxt;
            r_ctrl    <= w_ctrl_nxt;
            r_flag    <= w_flag_nxt;
            r_irq     <= r_flag & r_ctrl.ie;
            r_gate_s1 <= i_gate;
            r_gate_s2 <= r_gate_s1;
        end
    end

    assign o_count = r_count;
    assign o_max   = r_max;
    assign o_ctrl  = r_ctrl;
    assign o_flag  = r_flag;
    assign o_irq   = r_irq;

endmodule

// File: rtl/dsd7_pit.sv
// Four-channel interval timer bus slave: address decode, registered ack/read data, shared prescaler.
// Latency: ack one clock after select, held while selected; no backpressure (never stalls beyond that).
module dsd7_pit
    import dsd7_pit_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'hFFDC0100,
    parameter int          PRESCALE = 50,
    parameter int          NCH      = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    output logic            ack_o,
    input  logic            wr_i,
    input  logic [1:0]      sel_i,
    input  logic [31:0]     adr_i,
    input  logic [31:0]     dat_i,
    output logic [31:0]     dat_o,
    input  logic [NCH-1:0]  gate_i,
    output logic [NCH-1:0]  irq_o
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic        r_ack;
    logic [31:0] r_dat;
    logic [15:0] r_pre;

    logic        w_cs, w_win_ok, w_we, w_tick;
    logic [1:0]  w_ch, w_reg;
    logic [31:0] w_rdata;
    logic [31:0] w_count [NCH];
    logic [31:0] w_max   [NCH];
    ctrl_t       w_ctrl  [NCH];
    logic [NCH-1:0] w_flag, w_irq;
    logic        w_unused;

    assign w_cs     = cyc_i & stb_i & (adr_i[31:8] == BASE_ADR[31:8]);
    assign w_win_ok = (adr_i[7:6] == 2'b00);
    assign w_ch     = adr_i[5:4];
    assign w_reg    = adr_i[3:2];
    // Commit only on the first cycle of a transfer so a held strobe writes once.
    assign w_we     = w_cs & wr_i & ~r_ack & w_win_ok;
    assign w_tick   = (r_pre == PRE_MAX);
    assign w_unused = &{1'b0, adr_i[1:0]};

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic w_sel_ch;
        assign w_sel_ch = w_we & (w_ch == 2'(g));

        dsd7_pit_chan u_chan (
            .i_clk      (clk_i),
            .i_rst_n    (rst_i),
            .i_tick     (w_tick),
            .i_gate     (gate_i[g]),
            .i_we_count (w_sel_ch & (w_reg == REG_COUNT)),
            .i_we_max   (w_sel_ch & (w_reg == REG_MAX)),
            .i_we_ctrl  (w_sel_ch & (w_reg == REG_CTRL)),
            .i_we_stat  (w_sel_ch & (w_reg == REG_STAT)),
            .i_sel      (sel_i),
            .i_dat      (dat_i),
            .o_count    (w_count[g]),
            .o_max      (w_max[g]),
            .o_ctrl     (w_ctrl[g]),
            .o_flag     (w_flag[g]),
            .o_irq      (w_irq[g])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_win_ok) begin
            case (w_reg)
                REG_COUNT: w_rdata = w_count[w_ch];
                REG_MAX:   w_rdata = w_max[w_ch];
                REG_CTRL:  w_rdata = {27'd0, w_ctrl[w_ch]};
                default:   w_rdata = {31'd0, w_flag[w_ch]};
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_pre <= '0;
        end else begin
            r_ack <= w_cs;
            // Capture on the first read cycle, hold while acked; zero otherwise so the OR-bus stays clean.
            if (w_cs && !wr_i) r_dat <= r_ack ? r_dat : w_rdata;
            else               r_dat <= '0;
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
        end
    end

    assign ack_o = r_ack;
    assign dat_o = r_dat;
    assign irq_o = w_irq;

endmodule

// File: tb/tb_dsd7_pit.sv
// Directed bench for dsd7_pit with PRESCALE=2: ticks land on even clock edges after reset release.
module tb_dsd7_pit;

    localparam logic [31:0] BASE = 32'hFFDC0100;

    logic        clk_i, rst_i, cyc_i, stb_i, wr_i, ack_o;
    logic [1:0]  sel_i;
    logic [31:0] adr_i, dat_i, dat_o;
    logic [3:0]  gate_i, irq_o;

    int checks = 0;
    int errors = 0;
    int edge_n;
    int last_commit;

    dsd7_pit #(.BASE_ADR(BASE), .PRESCALE(2), .NCH(4)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .ack_o  (ack_o),
        .wr_i   (wr_i),
        .sel_i  (sel_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .gate_i (gate_i),
        .irq_o  (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Edge count since reset release; the prescaler wraps on every even edge.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    function automatic logic [31:0] ra(input int ch, input int r);
        return BASE + 32'(ch * 16 + r * 4);
    endfunction

    function automatic int next_tick(input int e);
        return (e % 2 == 0) ? e + 2 : e + 1;
    endfunction

    function automatic int n_even(input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) if (k % 2 == 0) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        cyc_i = 1'b1; stb_i = 1'b1; wr_i = 1'b1; adr_i = a; dat_i = d; sel_i = s;
        step();
        last_commit = edge_n;
        cyc_i = 1'b0; stb_i = 1'b0; wr_i = 1'b0;
        step();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ak);
        cyc_i = 1'b1; stb_i = 1'b1; wr_i = 1'b0; adr_i = a; sel_i = 2'b11;
        step();
        d = dat_o; ak = ack_o;
        cyc_i = 1'b0; stb_i = 1'b0;
        step();
    endtask

    task automatic align(input int p);
        for (int i = 0; i < 4 && (edge_n % 2) != p; i++) step();
    endtask

    task automatic test_reset();
        logic [31:0] d; logic ak;
        rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; wr_i = 1'b0;
        sel_i = 2'b00; adr_i = '0; dat_i = '0; gate_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack_o); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", dat_o); end
        checks++; if (irq_o !== 4'h0) begin errors++; $display("FAIL reset_irq got %h want 0", irq_o); end
        @(posedge clk_i); #1 rst_i = 1'b1;
        bus_read(ra(0, 2), d, ak);
        checks++; if (d !== 32'h0 || ak !== 1'b1) begin errors++; $display("FAIL reset_ctrl0 got %h/%b want 0/1", d, ak); end
        bus_read(ra(2, 1), d, ak);
        checks++; if (d !== 32'h0 || ak !== 1'b1) begin errors++; $display("FAIL reset_max2 got %h/%b want 0/1", d, ak); end
    endtask

    task automatic test_periodic();
        int e, f1, r1, n;
        bus_write(ra(0, 1), 32'd3, 2'b11);
        bus_write(ra(0, 2), 32'h1B, 2'b11);
        e  = last_commit;
        f1 = next_tick(e) + 6;
        n = 0;
        while (irq_o[0] !== 1'b1 && n < 40) begin step(); n++; end
        checks++;
        if (irq_o[0] !== 1'b1 || edge_n != f1 + 1) begin
            errors++; $display("FAIL periodic_first_irq irq=%b edge %0d want %0d", irq_o[0], edge_n, f1 + 1);
        end
        r1 = edge_n;
        bus_write(ra(0, 3), 32'h1, 2'b01);
        checks++; if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL periodic_clear got %b want 0", irq_o[0]); end
        n = 0;
        while (irq_o[0] !== 1'b1 && n < 40) begin step(); n++; end
        checks++;
        if (irq_o[0] !== 1'b1 || edge_n != r1 + 8) begin
            errors++; $display("FAIL periodic_period irq=%b edge %0d want %0d", irq_o[0], edge_n, r1 + 8);
        end
        bus_write(ra(0, 2), 32'h0, 2'b11);
        bus_write(ra(0, 3), 32'h1, 2'b01);
        step();
        checks++; if (irq_o[0] !== 1'b0) begin errors++; $display("FAIL periodic_disable got %b want 0", irq_o[0]); end
    endtask

    task automatic test_oneshot();
        int e, want, n;
        logic [31:0] d; logic ak;
        bus_write(ra(1, 1), 32'd5, 2'b11);
        bus_write(ra(1, 2), 32'h19, 2'b11);
        e    = last_commit;
        want = next_tick(e) + 11;
        n = 0;
        while (irq_o[1] !== 1'b1 && n < 60) begin step(); n++; end
        checks++;
        if (irq_o[1] !== 1'b1 || edge_n != want) begin
            errors++; $display("FAIL oneshot_irq irq=%b edge %0d want %0d", irq_o[1], edge_n, want);
        end
        bus_read(ra(1, 2), d, ak);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL oneshot_ctrl got %h want 00000010", d); end
        bus_read(ra(1, 0), d, ak);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_count got %h want 0", d); end
        bus_read(ra(1, 3), d, ak);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_stat got %h want 1", d); end
        checks++; if (irq_o[1] !== 1'b1) begin errors++; $display("FAIL oneshot_irq_hold got %b want 1", irq_o[1]); end
    endtask

    task automatic test_gating();
        int g, want;
        logic [31:0] d; logic ak;
        bus_write(ra(2, 1), 32'd10, 2'b11);
        bus_write(ra(2, 2), 32'h0D, 2'b11);
        repeat (40) step();
        bus_read(ra(2, 0), d, ak);
        checks++; if (d !== 32'd10) begin errors++; $display("FAIL gate_closed got %0d want 10", d); end
        gate_i[2] = 1'b1;
        g = edge_n;
        repeat (9) step();
        want = 10 - n_even(g + 3, g + 9);
        bus_read(ra(2, 0), d, ak);
        checks++; if (d !== 32'(want)) begin errors++; $display("FAIL gate_open got %0d want %0d", d, want); end
    endtask

    task automatic test_halfword();
        logic [31:0] d; logic ak;
        bus_write(ra(3, 1), 32'hAAAA5555, 2'b10);
        bus_read(ra(3, 1), d, ak);
        checks++; if (d !== 32'hAAAA0000) begin errors++; $display("FAIL half_hi got %h want aaaa0000", d); end
        bus_read(ra(3, 0), d, ak);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL max_keeps_count got %h want 0", d); end
        bus_write(ra(3, 1), 32'h12345678, 2'b01);
        bus_read(ra(3, 1), d, ak);
        checks++; if (d !== 32'hAAAA5678) begin errors++; $display("FAIL half_lo got %h want aaaa5678", d); end
        cyc_i = 1'b1; stb_i = 1'b1; wr_i = 1'b0; adr_i = 32'hFFDC0200; sel_i = 2'b11;
        step(); step();
        checks++;
        if (ack_o !== 1'b0 || dat_o !== 32'h0) begin
            errors++; $display("FAIL outside_window got %b/%h want 0/0", ack_o, dat_o);
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        step();
        bus_write(32'hFFDC0150, 32'hFFFFFFFF, 2'b11);
        bus_read(32'hFFDC0150, d, ak);
        checks++; if (d !== 32'h0 || ak !== 1'b1) begin errors++; $display("FAIL reserved_read got %h/%b want 0/1", d, ak); end
        bus_read(ra(1, 0), d, ak);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reserved_write got %h want 0", d); end
    endtask

    task automatic test_collisions();
        logic [31:0] d; logic ak;
        bus_write(ra(3, 1), 32'h0, 2'b11);
        bus_write(ra(3, 2), 32'h1B, 2'b11);
        step(); step();
        align(0);
        bus_write(ra(3, 3), 32'h1, 2'b01);
        checks++; if (irq_o[3] !== 1'b0) begin errors++; $display("FAIL every_tick_clear got %b want 0", irq_o[3]); end
        step();
        checks++; if (irq_o[3] !== 1'b1) begin errors++; $display("FAIL every_tick_set got %b want 1", irq_o[3]); end
        align(1);
        bus_write(ra(3, 3), 32'h1, 2'b01);
        checks++; if (irq_o[3] !== 1'b1) begin errors++; $display("FAIL set_beats_clear_irq got %b want 1", irq_o[3]); end
        bus_read(ra(3, 3), d, ak);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL set_beats_clear_stat got %h want 1", d); end

        bus_write(ra(0, 1), 32'd100, 2'b11);
        bus_write(ra(0, 2), 32'h0B, 2'b11);
        align(1);
        bus_write(ra(0, 0), 32'd7, 2'b11);
        bus_read(ra(0, 0), d, ak);
        checks++; if (d !== 32'd7) begin errors++; $display("FAIL write_beats_tick got %0d want 7", d); end
        align(1);
        bus_write(ra(0, 2), 32'h0B, 2'b11);
        bus_read(ra(0, 0), d, ak);
        checks++; if (d !== 32'd100) begin errors++; $display("FAIL ld_beats_tick got %0d want 100", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic ak;
        cyc_i = 1'b1; stb_i = 1'b1; wr_i = 1'b0; adr_i = ra(1, 3); sel_i = 2'b11;
        step();
        checks++;
        if (ack_o !== 1'b1 || dat_o !== 32'h1 || irq_o !== 4'b1010) begin
            errors++; $display("FAIL pre_reset got %b/%h/%b want 1/1/1010", ack_o, dat_o, irq_o);
        end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL async_ack got %b want 0", ack_o); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL async_dat got %h want 0", dat_o); end
        checks++; if (irq_o !== 4'h0) begin errors++; $display("FAIL async_irq got %b want 0", irq_o); end
        cyc_i = 1'b0; stb_i = 1'b0; gate_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) begin
                bus_read(ra(ch, r), d, ak);
                checks++;
                if (d !== 32'h0 || ak !== 1'b1) begin
                    errors++; $display("FAIL post_reset ch%0d reg%0d got %h/%b want 0/1", ch, r, d, ak);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_gating();
        test_halfword();
        test_collisions();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dsd7_pit.md
Name: dsd7_pit

Overview:
Four-channel programmable interval timer that sits upstream of the DSD7 PIC inside the MPU. It is a bus slave on the CPU-side bus, alongside the MMU and PIC. Its per-channel interrupt outputs drive PIC request inputs (e.g. i4..i7). It provides periodic or one-shot interrupts from a shared prescaled tick. Read data and ack are OR-combined with the other slaves, so both are zero whenever the block is not selected.

Parameters:
BASE_ADR, 32'hFFDC0100, slave base address; decode is adr_i[31:8]==BASE_ADR[31:8]
PRESCALE, 50, clocks per count tick (1 µs at 50 MHz); legal range 1..65535
NCH, 4, number of channels; fixed at 4 for this revision

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-low reset
cyc_i  in  1  bus cycle valid
stb_i  in  1  bus strobe
ack_o  out  1  transfer acknowledge
wr_i  in  1  1=write, 0=read
sel_i  in  2  16-bit half select: bit0=[15:0], bit1=[31:16]
adr_i  in  32  byte address
dat_i  in  32  write data
dat_o  out  32  read data; zero when not selected
gate_i  in  4  per-channel external gate
irq_o  out  4  per-channel level interrupt to PIC

Behaviour:
- Reset (rst_i low, async): all registers are 0. ack_o=0, dat_o=0, irq_o=0, prescaler=0.
- Chip select: cs = cyc_i & stb_i & (adr_i[31:8]==BASE_ADR[31:8]).
- Register map: adr_i[5:4]=channel, adr_i[3:2]=register.
  - 0 COUNT: 32 bit, R/W.
  - 1 MAX: 32 bit, R/W.
  - 2 CTRL: [0] EN, [1] AR (auto-reload), [2] GE (gate enable), [3] LD (write-only, reads 0), [4] IE.
  - 3 STAT: [0] FLAG; writing 1 clears it, writing 0 has no effect.
- adr_i[7:6]≠0 inside the window: reads return 0, writes are ignored, ack is still given.
- Bus handshake:
  - ack_o is registered and rises the cycle after cs. It stays high while cs stays high and drops the cycle after cs falls.
  - A write commits exactly once, on the cycle where cs=1 and ack_o=0.
  - Read data is registered alongside ack_o and held while ack_o=1. dat_o=0 whenever ack_o=0.
- Byte-lane writes: only halves with sel_i set are updated. The same rule applies to STAT and CTRL; bits [4:0] are in half 0.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick=1 for one clock when it wraps, i.e. one tick every PRESCALE clocks.
- Channel count on tick, when EN=1 and (GE=0 or gate_i[n]=1):
  - COUNT≠0: COUNT decrements.
  - COUNT==0: FLAG is set. If AR=1, COUNT←MAX. If AR=0, EN is cleared and COUNT stays 0.
- gate_i is sampled through a 2-flop synchronizer. Gate latency is 2 clocks.
- LD=1 on a CTRL write: COUNT←MAX in that cycle; the other CTRL bits are written normally.
- Writing MAX never alters COUNT.
- Precedence when events coincide:
  - Bus write to COUNT beats a tick decrement or reload.
  - LD beats a tick.
  - A FLAG set from underflow beats a STAT clear-write in the same cycle, so FLAG stays 1.
- irq_o[n] = FLAG & IE, registered, so there is 1 clock of latency from the FLAG set.
- MAX=0 with AR=1: FLAG is set on every tick.
- COUNT wraps never: a decrement only happens from a nonzero value.
- Reset asserted mid-transfer: ack_o drops immediately (async); the transfer is lost.

Decomposition:
- Shared package dsd7_pit_pkg:
  - register offsets (REG_COUNT=0, REG_MAX=1, REG_CTRL=2, REG_STAT=3);
  - CTRL bit indices (CTRL_EN, CTRL_AR, CTRL_GE, CTRL_LD, CTRL_IE);
  - a typedef for the channel control struct.
- One sub-module, dsd7_pit_chan, instantiated 4×. It holds COUNT, MAX, CTRL, FLAG, the gate synchronizer and the irq register. Its inputs are tick, a write strobe per register, sel and data.
- The top level holds the address decode, ack/dat_o registering and the prescaler.

Test Plan:
- Reset values: pulse rst_i low mid-simulation with ack_o high → ack_o, irq_o and dat_o go 0 asynchronously. Reading any register after reset returns 0.
- Periodic channel: PRESCALE=2. Ch0 MAX=3, CTRL=EN|AR|IE|LD (0x1B) → FLAG set every 8 clocks (4 ticks). irq_o[0] goes high 1 clock after the set. Writing STAT=1 clears irq_o[0] two cycles later.
- One-shot channel: ch1 MAX=5, CTRL=EN|IE|LD (0x19) → after 6 ticks FLAG=1, irq_o[1]=1, CTRL reads 0x10 (EN cleared) and COUNT reads 0.
- Gating: ch2 CTRL=EN|GE|LD, MAX=10, gate_i[2]=0 for 20 ticks → COUNT stays 10. Raising the gate starts decrementing after the 2-clock sync.
- Half-word write: write ch3 MAX=0xAAAA5555 with sel=2'b10 → MAX reads 0xAAAA0000. A read outside the window (adr 0xFFDC0200) → ack_o=0 and dat_o=0.
- Collisions: a STAT clear-write in the same cycle as an underflow → FLAG stays 1. A COUNT write of 7 coinciding with a tick → COUNT reads 7.
